data_sram_responder: RTL

- Target-side model/controller for the core's data SRAM request interface: accepts en/wen/addr/wdata from the execute stage and returns read data to the memory stage.
- Word-organised synchronous RAM with byte-lane write enables and 1-cycle read latency.
- Optional programmable wait states, signalled through a stall request into the pipeline stall controller.
- Used in simulation top level and FPGA builds in place of the external data SRAM.

---
 rtl/data_sram_if.sv | 28 ++
 rtl/data_sram_responder.sv | 133 +++++++++++++
 2 files changed

// File: rtl/data_sram_if.sv
// Data SRAM request bus between the execute/memory stages and the SRAM target.
// The requester holds the request stable while stallreq is high.
interface data_sram_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stallreq;

    modport master (
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata,
        input  stallreq
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata,
        output stallreq
    );
endinterface

// File: rtl/data_sram_responder.sv
// Word-organised data SRAM target: byte-lane writes, registered 1-cycle reads,
// optional wait states. Define DSRAM_PERF_CNT_EN for read/write commit counters.
module data_sram_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
`ifdef DSRAM_PERF_CNT_EN
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt,
`endif
    data_sram_if.slave  bus
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

    localparam int         DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_K = 4'(WAIT_CYCLES);

    logic [31:0]           mem [DEPTH];
    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  commit;
    logic                  stall;
    logic                  is_read;
    logic                  is_write;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  unused_addr;

    assign idx         = bus.data_sram_addr[ADDR_WIDTH+1:2];
    assign unused_addr = ^{bus.data_sram_addr[31:ADDR_WIDTH+2],
                           bus.data_sram_addr[1:0]};
    assign is_write    = commit & (|bus.data_sram_wen);
    assign is_read     = commit & ~(|bus.data_sram_wen);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        commit  = 1'b0;
        if (WAIT_CYCLES == 0) begin
            commit = bus.data_sram_en;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.data_sram_en) begin
                        stall   = 1'b1;
                        cnt_d   = WAIT_K - 4'd1;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!bus.data_sram_en) begin
                        state_d = S_IDLE;
                    end else if (cnt_q != 4'd0) begin
                        stall = 1'b1;
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        commit  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        // Reset wins over any pending access in the same cycle
        if (rst) begin
            stall  = 1'b0;
            commit = 1'b0;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (is_read) begin
            rdata_d = mem[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (is_write) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.data_sram_wen[i]) begin
                    mem[idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.data_sram_rdata = rdata_q;
    assign bus.stallreq        = stall;

`ifdef DSRAM_PERF_CNT_EN
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q + {31'd0, is_read};
        wr_cnt_d = wr_cnt_q + {31'd0, is_write};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= 32'd0;
            wr_cnt_q <= 32'd0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`endif

endmodule
